// File: rtl/sum_tx_sequencer.sv
// Frame sequencer: snapshots operands A and B on a send request and streams "A+B=SS[CR LF]"
// one byte at a time into a UART using a start/busy handshake, flagging missing acknowledges.
module sum_tx_sequencer #(
    parameter int unsigned CRLF_EN     = 1,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] operand_a,
    input  logic [3:0] operand_b,
    input  logic       send_req,
    input  logic       uart_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       seq_busy,
    output logic       frame_done,
    output logic       ack_err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ACK,
        WAIT_DONE,
        DONE
    } state_t;

    localparam logic [2:0] LAST_IDX  = (CRLF_EN != 0) ? 3'd7 : 3'd5;
    // The counter is compared before incrementing, so the abort edge lands ACK_TIMEOUT
    // cycles after the tx_start edge.
    localparam logic [7:0] ACK_LIMIT = 8'(ACK_TIMEOUT - 1);

    state_t     state;
    logic       req_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [4:0] sum_q;
    logic [2:0] idx_q;
    logic [7:0] ack_cnt_q;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    function automatic logic [7:0] frame_byte(
        input logic [2:0] idx,
        input logic [3:0] a,
        input logic [3:0] b,
        input logic [4:0] sum
    );
        logic [7:0] byte_val;
        byte_val = 8'h00;
        case (idx)
            3'd0:    byte_val = hex_char(a);
            3'd1:    byte_val = 8'h2B;
            3'd2:    byte_val = hex_char(b);
            3'd3:    byte_val = 8'h3D;
            3'd4:    byte_val = hex_char({3'b000, sum[4]});
            3'd5:    byte_val = hex_char(sum[3:0]);
            3'd6:    byte_val = 8'h0D;
            default: byte_val = 8'h0A;
        endcase
        return byte_val;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_q      <= 1'b1;
            a_q        <= 4'h0;
            b_q        <= 4'h0;
            sum_q      <= 5'h00;
            idx_q      <= 3'd0;
            ack_cnt_q  <= 8'h00;
            tx_data    <= 8'h00;
            tx_start   <= 1'b0;
            seq_busy   <= 1'b0;
            frame_done <= 1'b0;
            ack_err    <= 1'b0;
        end else begin
            req_q      <= send_req;
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (send_req && !req_q) begin
                        a_q      <= operand_a;
                        b_q      <= operand_b;
                        sum_q    <= {1'b0, operand_a} + {1'b0, operand_b};
                        ack_err  <= 1'b0;
                        idx_q    <= 3'd0;
                        seq_busy <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (!uart_busy) begin
                        tx_data   <= frame_byte(idx_q, a_q, b_q, sum_q);
                        tx_start  <= 1'b1;
                        ack_cnt_q <= 8'h00;
                        state     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (uart_busy) begin
                        state <= WAIT_DONE;
                    end else if (ack_cnt_q == ACK_LIMIT) begin
                        ack_err  <= 1'b1;
                        seq_busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_busy) begin
                        if (idx_q == LAST_IDX) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            state <= START;
                        end
                    end
                end
                DONE: begin
                    seq_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    seq_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_tx_sequencer.sv
// Directed bench for sum_tx_sequencer: an 8-byte (CR LF) and a 6-byte instance share stimulus
// and a behavioural UART whose busy pulse follows each tx_start of the 8-byte instance.
module tb_sum_tx_sequencer;

    logic       clk;
    logic       reset_n;
    logic [3:0] operand_a;
    logic [3:0] operand_b;
    logic       send_req;
    logic       model_busy;
    logic       hold_busy;
    logic       uart_busy;

    logic [7:0] tx_data,  tx_data6;
    logic       tx_start, tx_start6;
    logic       seq_busy, seq_busy6;
    logic       frame_done, frame_done6;
    logic       ack_err, ack_err6;

    int n_tests;
    int n_fail;
    int n_start, n_start6, n_done, n_done6;
    logic [7:0] rx_q[$];
    logic [7:0] rx6_q[$];
    bit model_en;
    int busy_cycles;

    assign uart_busy = model_busy | hold_busy;

    sum_tx_sequencer #(.CRLF_EN(1), .ACK_TIMEOUT(15)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .send_req  (send_req),
        .uart_busy (uart_busy),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .seq_busy  (seq_busy),
        .frame_done(frame_done),
        .ack_err   (ack_err)
    );

    sum_tx_sequencer #(.CRLF_EN(0), .ACK_TIMEOUT(15)) dut6 (
        .clk       (clk),
        .reset_n   (reset_n),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .send_req  (send_req),
        .uart_busy (uart_busy),
        .tx_data   (tx_data6),
        .tx_start  (tx_start6),
        .seq_busy  (seq_busy6),
        .frame_done(frame_done6),
        .ack_err   (ack_err6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: all outputs are sampled on the falling edge.
    initial begin
        n_start = 0; n_start6 = 0; n_done = 0; n_done6 = 0;
        forever begin
            @(negedge clk);
            if (tx_start) begin rx_q.push_back(tx_data); n_start++; end
            if (tx_start6) begin rx6_q.push_back(tx_data6); n_start6++; end
            if (frame_done) n_done++;
            if (frame_done6) n_done6++;
        end
    end

    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (model_en && tx_start && reset_n) begin
                model_busy = 1'b1;
                repeat (busy_cycles) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic raise_req();
        @(negedge clk);
        send_req = 1'b0;
        @(negedge clk);
        send_req = 1'b1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!seq_busy && !seq_busy6) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({tx_data, tx_start, seq_busy, frame_done, ack_err} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs got %h want 000",
                     {tx_data, tx_start, seq_busy, frame_done, ack_err});
        end
        n_tests++;
        if ({tx_data6, tx_start6, seq_busy6, frame_done6, ack_err6} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs6 got %h want 000",
                     {tx_data6, tx_start6, seq_busy6, frame_done6, ack_err6});
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++;
        if (seq_busy !== 1'b0 || n_start != 0) begin
            n_fail++;
            $display("FAIL post_reset_idle got busy=%b starts=%0d want 0 0", seq_busy, n_start);
        end
    endtask

    task automatic test_crlf_frame();
        logic [7:0] exp [8];
        int base, base6, sbase, dbase, dbase6;
        bit ok;
        exp = '{8'h37, 8'h2B, 8'h39, 8'h3D, 8'h31, 8'h30, 8'h0D, 8'h0A};
        base = rx_q.size(); base6 = rx6_q.size();
        sbase = n_start; dbase = n_done; dbase6 = n_done6;
        model_en = 1'b1; busy_cycles = 10;
        operand_a = 4'h7; operand_b = 4'h9;
        raise_req();
        @(negedge clk);
        send_req = 1'b0;
        wait_idle(600, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL crlf_idle_timeout got busy want idle"); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (n_start - sbase != 8) begin
            n_fail++;
            $display("FAIL crlf_start_count got %0d want 8", n_start - sbase);
        end
        if (rx_q.size() >= base + 8) begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (rx_q[base + i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL crlf_byte[%0d] got %h want %h", i, rx_q[base + i], exp[i]);
                end
            end
        end
        if (rx6_q.size() >= base6 + 6) begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (rx6_q[base6 + i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL nocrlf_byte[%0d] got %h want %h", i, rx6_q[base6 + i], exp[i]);
                end
            end
        end
        n_tests++;
        if (n_done - dbase != 1 || n_done6 - dbase6 != 1) begin
            n_fail++;
            $display("FAIL crlf_frame_done got %0d/%0d want 1/1", n_done - dbase, n_done6 - dbase6);
        end
        n_tests++;
        if (ack_err !== 1'b0) begin n_fail++; $display("FAIL crlf_ack_err got %b want 0", ack_err); end
    endtask

    task automatic test_operand_change();
        logic [7:0] exp [6];
        int base6, dbase6;
        bit ok;
        exp = '{8'h46, 8'h2B, 8'h46, 8'h3D, 8'h31, 8'h45};
        base6 = rx6_q.size(); dbase6 = n_done6;
        model_en = 1'b1; busy_cycles = 4;
        operand_a = 4'hF; operand_b = 4'hF;
        raise_req();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx6_q.size() >= base6 + 2) break;
        end
        operand_a = 4'h0;
        send_req = 1'b0;
        wait_idle(600, ok);
        n_tests++;
        if (!ok || rx6_q.size() != base6 + 6) begin
            n_fail++;
            $display("FAIL ff_frame_len got %0d want 6", rx6_q.size() - base6);
        end
        if (rx6_q.size() >= base6 + 6) begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (rx6_q[base6 + i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL ff_byte[%0d] got %h want %h", i, rx6_q[base6 + i], exp[i]);
                end
            end
        end
        n_tests++;
        if (n_done6 - dbase6 != 1) begin
            n_fail++;
            $display("FAIL ff_frame_done got %0d want 1", n_done6 - dbase6);
        end
    endtask

    task automatic test_timeout();
        int sbase, dbase, k;
        bit seen, ok;
        model_en = 1'b0;
        sbase = n_start; dbase = n_done;
        operand_a = 4'h0; operand_b = 4'h0;
        raise_req();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_start) begin seen = 1'b1; break; end
        end
        n_tests++;
        if (!seen || tx_data !== 8'h30) begin
            n_fail++;
            $display("FAIL timeout_first_byte got seen=%b data=%h want 1 30", seen, tx_data);
        end
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ack_err) begin k = i; break; end
        end
        n_tests++;
        if (k != 15) begin n_fail++; $display("FAIL timeout_latency got %0d want 15", k); end
        n_tests++;
        if (seq_busy !== 1'b0 || ack_err6 !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_state got busy=%b err6=%b want 0 1", seq_busy, ack_err6);
        end
        repeat (20) @(negedge clk);
        n_tests++;
        if (n_start - sbase != 1 || n_done != dbase || ack_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_abort got starts=%0d dones=%0d err=%b want 1 0 1",
                     n_start - sbase, n_done - dbase, ack_err);
        end
        model_en = 1'b1; busy_cycles = 2;
        raise_req();
        @(negedge clk);
        send_req = 1'b0;
        n_tests++;
        if (ack_err !== 1'b0 || seq_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_clear got err=%b busy=%b want 0 1", ack_err, seq_busy);
        end
        wait_idle(400, ok);
        n_tests++;
        if (!ok || ack_err !== 1'b0 || n_done - dbase != 1) begin
            n_fail++;
            $display("FAIL timeout_recover got ok=%b err=%b dones=%0d want 1 0 1",
                     ok, ack_err, n_done - dbase);
        end
    endtask

    task automatic test_req_held();
        int sbase, dbase;
        bit ok;
        model_en = 1'b1; busy_cycles = 3;
        sbase = n_start; dbase = n_done;
        operand_a = 4'h2; operand_b = 4'h5;
        raise_req();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n_start - sbase >= 3) break;
        end
        send_req = 1'b0;
        @(negedge clk);
        send_req = 1'b1;
        wait_idle(400, ok);
        repeat (6) @(negedge clk);
        n_tests++;
        if (!ok || n_start - sbase != 8 || n_done - dbase != 1) begin
            n_fail++;
            $display("FAIL held_one_frame got starts=%0d dones=%0d want 8 1",
                     n_start - sbase, n_done - dbase);
        end
        raise_req();
        wait_idle(400, ok);
        send_req = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (!ok || n_start - sbase != 16 || n_done - dbase != 2) begin
            n_fail++;
            $display("FAIL held_second_frame got starts=%0d dones=%0d want 16 2",
                     n_start - sbase, n_done - dbase);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [8];
        int sbase, dbase, base;
        bit ok;
        exp = '{8'h37, 8'h2B, 8'h39, 8'h3D, 8'h31, 8'h30, 8'h0D, 8'h0A};
        model_en = 1'b1; busy_cycles = 10;
        operand_a = 4'h7; operand_b = 4'h9;
        sbase = n_start;
        raise_req();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (n_start - sbase >= 3) break;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({tx_data, tx_start, seq_busy, frame_done, ack_err} !== 12'h000 ||
            {tx_data6, tx_start6, seq_busy6, frame_done6, ack_err6} !== 12'h000) begin
            n_fail++;
            $display("FAIL midreset_outputs got %h %h want 000 000",
                     {tx_data, tx_start, seq_busy, frame_done, ack_err},
                     {tx_data6, tx_start6, seq_busy6, frame_done6, ack_err6});
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        sbase = n_start; dbase = n_done;
        repeat (30) @(negedge clk);
        n_tests++;
        if (n_start != sbase || seq_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_ignored_req got starts=%0d busy=%b want 0 0",
                     n_start - sbase, seq_busy);
        end
        base = rx_q.size();
        raise_req();
        @(negedge clk);
        send_req = 1'b0;
        wait_idle(600, ok);
        repeat (3) @(negedge clk);
        n_tests++;
        if (!ok || n_start - sbase != 8 || n_done - dbase != 1) begin
            n_fail++;
            $display("FAIL midreset_new_frame got starts=%0d dones=%0d want 8 1",
                     n_start - sbase, n_done - dbase);
        end
        n_tests++;
        if (rx_q.size() < base + 8 || rx_q[base + 7] !== exp[7] || rx_q[base] !== exp[0]) begin
            n_fail++;
            $display("FAIL midreset_frame_bytes got len=%0d want 8 starting 37 ending 0a",
                     rx_q.size() - base);
        end
    endtask

    task automatic test_busy_hold();
        int sbase, dbase, early;
        bit ok;
        model_en = 1'b0;
        sbase = n_start; dbase = n_done;
        operand_a = 4'h3; operand_b = 4'h4;
        @(negedge clk);
        hold_busy = 1'b1;
        raise_req();
        early = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx_start) early++;
        end
        hold_busy = 1'b0;
        model_en = 1'b1; busy_cycles = 2;
        send_req = 1'b0;
        n_tests++;
        if (early != 0 || n_start != sbase) begin
            n_fail++;
            $display("FAIL busyhold_early_start got %0d want 0", early);
        end
        @(negedge clk);
        n_tests++;
        if (tx_start !== 1'b1 || tx_data !== 8'h33) begin
            n_fail++;
            $display("FAIL busyhold_first_start got start=%b data=%h want 1 33", tx_start, tx_data);
        end
        wait_idle(400, ok);
        repeat (3) @(negedge clk);
        n_tests++;
        if (!ok || n_start - sbase != 8 || n_done - dbase != 1) begin
            n_fail++;
            $display("FAIL busyhold_frame got starts=%0d dones=%0d want 8 1",
                     n_start - sbase, n_done - dbase);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        reset_n = 1'b0; operand_a = 4'h0; operand_b = 4'h0; send_req = 1'b0;
        hold_busy = 1'b0; model_en = 1'b0; busy_cycles = 10;
        test_reset();
        test_crlf_frame();
        test_operand_change();
        test_timeout();
        test_req_held();
        test_reset_mid();
        test_busy_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
